// File: rtl/sysbus_arbiter_if.sv
// Bundle of requester-side and Sysbus-side signals around the two-requester arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding requesters and bus.
interface sysbus_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
);
  logic [1:0]        m_reqcyc;
  logic [ADDR_W-1:0] m_req    [2];
  logic [TAG_W-1:0]  m_reqtag [2];
  logic [1:0]        m_reqack;
  logic [1:0]        m_respcyc;
  logic [DATA_W-1:0] m_resp;
  logic [1:0]        m_respack;

  logic              s_reqcyc;
  logic [ADDR_W-1:0] s_req;
  logic [TAG_W-1:0]  s_reqtag;
  logic              s_reqack;
  logic              s_respcyc;
  logic [DATA_W-1:0] s_resp;
  logic              s_respack;

  modport slave (
    input  m_reqcyc, m_req, m_reqtag, m_respack,
    output m_reqack, m_respcyc, m_resp,
    output s_reqcyc, s_req, s_reqtag, s_respack,
    input  s_reqack, s_respcyc, s_resp
  );

  modport master (
    output m_reqcyc, m_req, m_reqtag, m_respack,
    input  m_reqack, m_respcyc, m_resp,
    input  s_reqcyc, s_req, s_reqtag, s_respack,
    output s_reqack, s_respcyc, s_resp
  );
endinterface

// File: rtl/sysbus_arbiter.sv
// Shares one Sysbus port between instruction fetch (0) and data memory (1), one transaction at a time.
// Define SYSBUS_ARB_FIXED_PRIO_EN to make requester 1 win every tie instead of round-robin.
module sysbus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
) (
  input  logic             clk,
  input  logic             reset,
  sysbus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q;
  logic              last_q;
  logic              got_beat_q;
  logic              reqcyc_q;
  logic [ADDR_W-1:0] req_q;
  logic [TAG_W-1:0]  tag_q;

  logic              tie_pick;
  logic              winner;
  logic              burst_end;

`ifdef SYSBUS_ARB_FIXED_PRIO_EN
  assign tie_pick = 1'b1;
`else
  assign tie_pick = ~last_q;
`endif

  assign winner    = bus.m_reqcyc[1] & (~bus.m_reqcyc[0] | tie_pick);
  // A burst is over only once at least one beat has been seen and respcyc drops.
  assign burst_end = got_beat_q & ~bus.s_respcyc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      got_beat_q <= 1'b0;
      reqcyc_q   <= 1'b0;
      req_q      <= '0;
      tag_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (|bus.m_reqcyc) begin
            owner_q    <= winner;
            req_q      <= bus.m_req[winner];
            tag_q      <= bus.m_reqtag[winner];
            reqcyc_q   <= 1'b1;
            got_beat_q <= 1'b0;
          end
        end
        REQ: begin
          if (bus.s_reqack) reqcyc_q <= 1'b0;
        end
        RESP: begin
          if (bus.s_respcyc) got_beat_q <= 1'b1;
          else if (got_beat_q) last_q <= owner_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.m_reqack  = '0;
    bus.m_respcyc = '0;
    bus.s_respack = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.m_reqcyc) state_d = REQ;
      end
      REQ: begin
        bus.m_reqack[owner_q] = bus.s_reqack;
        if (bus.s_reqack) state_d = RESP;
      end
      RESP: begin
        bus.m_respcyc[owner_q] = bus.s_respcyc;
        bus.s_respack          = bus.m_respack[owner_q];
        if (burst_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.m_resp   = bus.s_resp;
  assign bus.s_reqcyc = reqcyc_q;
  assign bus.s_req    = req_q;
  assign bus.s_reqtag = tag_q;

endmodule
